// File: rtl/data_cache.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// data_cache
//
// Direct-mapped, write-back, write-allocate data cache between the pipeline
// MEM stage and a line-wide backing data memory. Load and store hits complete
// in the same cycle they are presented. A miss stalls the requester while a
// dirty victim is written back and the requested line is fetched. The
// requester keeps its request asserted throughout, and the request then hits
// ("replay") once the fill has landed.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   is_input_valid    MEM stage presents a load or store
//   addr              byte address (bits [1:0] ignored)
//   mem_rw            1 = store, 0 = load
//   din               store data
//   is_ready          cache is idle and can evaluate a request
//   is_output_valid   request completes this cycle
//   is_hit            current request hits
//   dout              load data (valid with is_output_valid && !mem_rw)
//   mem_req/mem_we    backing-memory request; 1 = write-back, 0 = fetch
//   mem_addr          line-aligned byte address of the transaction
//   mem_wdata         victim line, word 0 in the LSBs
//   mem_rdata         fetched line, word 0 in the LSBs
//   mem_ack           one-cycle pulse completing the current transaction
//   num_hits          hit counter (replay hits not counted)
//   num_misses        miss counter
// ---------------------------------------------------------------------------
module data_cache #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_rw,
  input  logic [31:0]             din,
  output logic                    is_ready,
  output logic                    is_output_valid,
  output logic                    is_hit,
  output logic [31:0]             dout,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [32*LINE_WORDS-1:0] mem_wdata,
  input  logic [32*LINE_WORDS-1:0] mem_rdata,
  input  logic                    mem_ack,
  output logic [31:0]             num_hits,
  output logic [31:0]             num_misses
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - OFF_W - IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state;

  // Per-line state. Valid/dirty are reset; tags and data are plain storage.
  logic [NUM_SETS-1:0] valid_bits;
  logic [NUM_SETS-1:0] dirty_bits;
  logic [TAG_W-1:0]    tags  [NUM_SETS];
  logic [31:0]         lines [NUM_SETS][LINE_WORDS];

  // Set when a fill completes so the replayed hit is not counted as a hit.
  logic replay;

  logic [OFF_W-1:0] req_offset;
  logic [IDX_W-1:0] req_index;
  logic [TAG_W-1:0] req_tag;
  logic             line_hit;
  logic             in_idle;
  logic             mem_done;
  logic             unused_addr_bits;

  // Address decomposition: | tag | index | word offset | byte offset |
  assign req_offset       = addr[2 +: OFF_W];
  assign req_index        = addr[OFF_W+2 +: IDX_W];
  assign req_tag          = addr[31 -: TAG_W];
  assign unused_addr_bits = ^addr[1:0];

  assign line_hit = valid_bits[req_index] && (tags[req_index] == req_tag);

  // Reset forces all handshake outputs low even though the state register
  // only clears at the next edge.
  assign in_idle         = (state == IDLE) && !reset;
  assign is_ready        = in_idle;
  assign is_hit          = in_idle && is_input_valid && line_hit;
  assign is_output_valid = is_hit;
  assign dout            = lines[req_index][req_offset];

  assign mem_req  = (state != IDLE) && !reset;
  assign mem_we   = (state == WRITEBACK);
  assign mem_done = mem_req && mem_ack;

  // The victim sits at the requested index, so only the tag differs between
  // the write-back address and the fetch address.
  always_comb begin
    if (state == WRITEBACK) begin
      mem_addr = {tags[req_index], req_index, {(OFF_W+2){1'b0}}};
    end else begin
      mem_addr = {req_tag, req_index, {(OFF_W+2){1'b0}}};
    end
  end

  always_comb begin
    mem_wdata = '0;
    for (int w = 0; w < LINE_WORDS; w++) begin
      mem_wdata[32*w +: 32] = lines[req_index][w];
    end
  end

  // Control state machine, valid/dirty bookkeeping and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      valid_bits <= '0;
      dirty_bits <= '0;
      replay     <= 1'b0;
      num_hits   <= '0;
      num_misses <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_input_valid) begin
            if (line_hit) begin
              if (!replay) begin
                num_hits <= num_hits + 32'd1;
              end
              replay <= 1'b0;
              if (mem_rw) begin
                dirty_bits[req_index] <= 1'b1;
              end
            end else begin
              num_misses <= num_misses + 32'd1;
              if (valid_bits[req_index] && dirty_bits[req_index]) begin
                state <= WRITEBACK;
              end else begin
                state <= ALLOCATE;
              end
            end
          end
        end
        WRITEBACK: begin
          if (mem_done) begin
            state <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_done) begin
            valid_bits[req_index] <= 1'b1;
            dirty_bits[req_index] <= 1'b0;
            replay                <= 1'b1;
            state                 <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Tag and data storage: line fill on fetch completion, word write on a
  // store hit. The two never coincide because a fill only happens outside
  // IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ALLOCATE && mem_done) begin
        tags[req_index] <= req_tag;
        for (int w = 0; w < LINE_WORDS; w++) begin
          lines[req_index][w] <= mem_rdata[32*w +: 32];
        end
      end else if (is_hit && mem_rw) begin
        lines[req_index][req_offset] <= din;
      end
    end
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and a line-wide backing data memory.
- Serves word loads/stores from the MEM stage. Stalls the pipeline on a miss while it writes back a dirty victim line and fetches the requested line.
- Keeps hit and miss counters for performance reporting at halt.

Parameters:
- NUM_SETS, 16, number of lines; power of 2, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- is_input_valid  in  1  MEM stage presents a load or store
- addr  in  32  byte address; bits [1:0] ignored
- mem_rw  in  1  1 = store, 0 = load
- din  in  32  store data
- is_ready  out  1  cache is in IDLE and can evaluate a request
- is_output_valid  out  1  request completes this cycle
- is_hit  out  1  current request hits
- dout  out  32  load data, valid when is_output_valid && !mem_rw
- mem_req  out  1  backing-memory transaction request
- mem_we  out  1  1 = line write-back, 0 = line fetch
- mem_addr  out  32  line-aligned byte address
- mem_wdata  out  32*LINE_WORDS  victim line; word 0 in the LSBs
- mem_rdata  in  32*LINE_WORDS  fetched line
- mem_ack  in  1  one-cycle pulse; completes the current transaction
- num_hits  out  32  hit counter
- num_misses  out  32  miss counter

Behaviour:
- Address split, with O = log2(LINE_WORDS) and I = log2(NUM_SETS):
  - word offset = addr[O+1:2]
  - index = addr[O+1+I:O+2]
  - tag = the remaining upper bits
- Per-line storage: valid, dirty, tag, data.
- Reset:
  - Clears all valid and dirty bits, the counters and the replay flag. State goes to IDLE.
  - While reset is high, is_ready, is_output_valid, is_hit and mem_req are 0.
  - Reset mid-transaction abandons it; mem_req drops in the cycle reset is sampled.
- State machine: IDLE, WRITEBACK, ALLOCATE.
- is_ready = (state == IDLE) && !reset.
- IDLE, is_input_valid=1, hit (valid && tag match):
  - is_hit=1 and is_output_valid=1, combinationally in the same cycle.
  - Load: dout = the selected word. Zero-latency hit.
  - Store: din is written into the word at the posedge and dirty is set.
  - num_hits increments unless the replay flag is set. The replay flag clears.
- IDLE, is_input_valid=1, miss:
  - is_hit=0 and is_output_valid=0.
  - num_misses increments.
  - Next state is WRITEBACK if the victim is valid && dirty, else ALLOCATE.
- IDLE, is_input_valid=0: all outputs idle and no state change. dout is don't-care.
- Request stability: the requester holds addr, mem_rw and din stable from assertion until the cycle is_output_valid=1. The cache does not latch them.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr = {victim tag, index, zero offset}, mem_wdata = victim data.
  - On mem_ack: next state is ALLOCATE.
- ALLOCATE:
  - mem_req=1, mem_we=0, mem_addr = the request's line address.
  - On mem_ack: line <= mem_rdata, tag <= request tag, valid=1, dirty=0, replay flag set, next state IDLE.
- Replay: the held request then hits in IDLE, so a miss costs the memory latency plus 1 cycle. The replay hit does not count toward num_hits.
- Memory protocol:
  - mem_req stays high and mem_addr, mem_we, mem_wdata stay stable until mem_ack.
  - Back-to-back requests (WRITEBACK then ALLOCATE) are legal. The cycle after an ack with mem_req high begins a new transaction.
  - mem_ack while mem_req=0 is ignored.
- Counters are 32-bit and wrap from 0xFFFF_FFFF to 0.
- Stores in WRITEBACK or ALLOCATE do not happen, because the request waits for the replay.

Test Plan:
- Cold load at 0x0000_0104 with memory line words {A,B,C,D} and ack after 3 cycles → WRITEBACK skipped; ALLOCATE mem_addr=0x0000_0100; the replay cycle gives dout=B, is_hit=1; num_misses=1, num_hits=0.
- Immediately reload 0x0000_0108 → same-cycle is_output_valid=1, dout=C, num_hits=1, mem_req stays 0.
- Store 0x1234_5678 to 0x0000_0100 (hit), then load 0x0000_1100 (same index 0, tag 0x11) → WRITEBACK with mem_addr=0x0000_0100 and mem_wdata word0=0x1234_5678, then ALLOCATE with mem_addr=0x0000_1100; num_misses increments by 1.
- Clean-line conflict: load 0x0000_0200, then 0x0000_1200 → no WRITEBACK; ALLOCATE only.
- Assert reset for 1 cycle while in ALLOCATE with no ack → mem_req=0 the next cycle, is_ready=1 after release, and a load at 0x0000_0104 misses again.
- mem_ack pulsed while idle and mem_ack delayed 10 cycles → the idle pulse is ignored, and mem_req and mem_addr stay stable for all 10 cycles.
